// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: command engine on the user side of a UART FIFO pair.
// Pops bytes from a first-word-fall-through RX FIFO, parses a register
// read/write protocol, owns a small register bank and pushes one response
// byte per command into the TX FIFO.
//
// Protocol:
//   'W' (0x57), addr, data -> reg[addr] <= data, response 'K' (0x4B)
//   'R' (0x52), addr       -> response reg[addr]
//   other opcode           -> response '?' (0x3F), cmd_err pulse
//   addr >= NUM_REGS       -> response 'E' (0x45), cmd_err pulse, no write
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-low reset
//   rx_data        RX FIFO head byte (valid when fifo_rx_empty = 0)
//   fifo_rx_empty  RX FIFO empty flag
//   rd             RX FIFO pop, one pulse per consumed byte
//   tx_data        response byte presented to the TX FIFO
//   fifo_tx_full   TX FIFO full flag
//   wr             TX FIFO push, one pulse per response
//   reg_bank       flattened registers, reg i at [8i+7:8i]
//   busy           high whenever the engine is not idle
//   cmd_err        one-cycle pulse on bad opcode, bad address or timeout
module uart_cmd_responder #(
  parameter int unsigned NUM_REGS       = 8,
  parameter int unsigned ADDR_BITS      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TO_BITS        = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  fifo_rx_empty,
  output logic                  rd,
  output logic [7:0]            tx_data,
  input  logic                  fifo_tx_full,
  output logic                  wr,
  output logic [NUM_REGS*8-1:0] reg_bank,
  output logic                  busy,
  output logic                  cmd_err
);

  localparam logic [7:0] OpWrite  = 8'h57;
  localparam logic [7:0] OpRead   = 8'h52;
  localparam logic [7:0] RespOk   = 8'h4B;
  localparam logic [7:0] RespErr  = 8'h45;
  localparam logic [7:0] RespUnk  = 8'h3F;
  localparam logic [TO_BITS-1:0] ToLast = TO_BITS'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StGetAddr, StGetData, StSend} state_e;

  state_e                 state_q, state_d;
  logic                   op_wr_q, op_wr_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   addr_bad_q, addr_bad_d;
  logic [7:0]             resp_q, resp_d;
  logic [TO_BITS-1:0]     to_cnt_q, to_cnt_d;
  logic                   err_q, err_d;
  logic [7:0]             regs_q [NUM_REGS];

  logic                   accept;
  logic                   to_expire;
  logic                   reg_we;
  logic [ADDR_BITS-1:0]   rx_idx;
  logic                   rx_bad;

  assign accept = rst && (state_q != StSend) && !fifo_rx_empty;
  assign rx_idx = rx_data[ADDR_BITS-1:0];
  assign rx_bad = 32'(rx_data) >= NUM_REGS;

  always_comb begin
    state_d    = state_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    addr_bad_d = addr_bad_q;
    resp_d     = resp_q;
    to_cnt_d   = to_cnt_q;
    err_d      = 1'b0;
    to_expire  = 1'b0;
    reg_we     = 1'b0;

    case (state_q)
      StIdle: begin
        to_cnt_d = '0;
        if (accept) begin
          if (rx_data == OpWrite) begin
            op_wr_d = 1'b1;
            state_d = StGetAddr;
          end else if (rx_data == OpRead) begin
            op_wr_d = 1'b0;
            state_d = StGetAddr;
          end else begin
            resp_d  = RespUnk;
            err_d   = 1'b1;
            state_d = StSend;
          end
        end
      end

      StGetAddr: begin
        if (accept) begin
          to_cnt_d = '0;
          if (op_wr_q) begin
            addr_d     = rx_idx;
            addr_bad_d = rx_bad;
            state_d    = StGetData;
          end else begin
            resp_d  = rx_bad ? RespErr : regs_q[rx_idx];
            err_d   = rx_bad;
            state_d = StSend;
          end
        end else if (to_cnt_q == ToLast) begin
          to_expire = 1'b1;
          to_cnt_d  = '0;
          state_d   = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      StGetData: begin
        if (accept) begin
          to_cnt_d = '0;
          reg_we   = !addr_bad_q;
          resp_d   = addr_bad_q ? RespErr : RespOk;
          err_d    = addr_bad_q;
          state_d  = StSend;
        end else if (to_cnt_q == ToLast) begin
          to_expire = 1'b1;
          to_cnt_d  = '0;
          state_d   = StIdle;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      StSend: begin
        // Waits on a full TX FIFO forever; the timeout only covers packet gaps.
        if (!fifo_tx_full) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      addr_bad_q <= 1'b0;
      resp_q     <= '0;
      to_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      addr_bad_q <= addr_bad_d;
      resp_q     <= resp_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_we) begin
      regs_q[addr_q] <= rx_data;
    end
  end

  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_bank
    assign reg_bank[8*i +: 8] = regs_q[i];
  end

  assign rd      = accept;
  assign wr      = rst && (state_q == StSend) && !fifo_tx_full;
  assign tx_data = resp_q;
  assign busy    = rst && (state_q != StIdle);
  // Decode errors are registered so they land after the offending pop;
  // a timeout has no pop and is flagged in the expiry cycle itself.
  assign cmd_err = rst && (err_q || to_expire);

endmodule

// File: tb/tb_uart_cmd_responder.sv
module tb_uart_cmd_responder;

  localparam int unsigned NR = 8;
  localparam int unsigned AB = 3;
  localparam int unsigned TO = 16;
  localparam int unsigned TB = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          fifo_rx_empty;
  logic          rd;
  logic [7:0]    tx_data;
  logic          fifo_tx_full;
  logic          wr;
  logic [NR*8-1:0] reg_bank;
  logic          busy;
  logic          cmd_err;

  uart_cmd_responder #(
    .NUM_REGS      (NR),
    .ADDR_BITS     (AB),
    .TIMEOUT_CYCLES(TO),
    .TO_BITS       (TB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .fifo_rx_empty(fifo_rx_empty),
    .rd           (rd),
    .tx_data      (tx_data),
    .fifo_tx_full (fifo_tx_full),
    .wr           (wr),
    .reg_bank     (reg_bank),
    .busy         (busy),
    .cmd_err      (cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         n;
    logic [7:0] resp;
    int         errs;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] q[$];
  logic [7:0] exp_regs[NR];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int rd_cnt, last_rd_cyc, wr_cnt, wr_cyc, err_cnt, err_cyc, err_with_rd;
  logic [7:0] wr_byte;
  logic s_rd, s_wr, s_err, s_busy;
  logic [NR*8-1:0] s_bank;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_rx();
    fifo_rx_empty = (q.size() == 0);
    rx_data       = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    drive_rx();
  endtask

  task automatic clear_stats();
    rd_cnt = 0; last_rd_cyc = -100; wr_cnt = 0; wr_cyc = -100;
    err_cnt = 0; err_cyc = -100; err_with_rd = 0; wr_byte = 8'h00;
  endtask

  // Sample at the falling edge, then move to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    s_rd = rd; s_wr = wr; s_err = cmd_err; s_busy = busy; s_bank = reg_bank;
    if (rd) begin rd_cnt++; last_rd_cyc = cyc; end
    if (wr) begin wr_cnt++; wr_cyc = cyc; wr_byte = tx_data; end
    if (cmd_err) begin err_cnt++; err_cyc = cyc; if (rd) err_with_rd++; end
    @(posedge clk);
    #1;
    if (s_rd && q.size() != 0) void'(q.pop_front());
    drive_rx();
  endtask

  function automatic logic [63:0] exp_bank();
    logic [63:0] b;
    b = '0;
    for (int i = 0; i < int'(NR); i++) b[8*i +: 8] = exp_regs[i];
    return b;
  endfunction

  task automatic wait_wr();
    for (int i = 0; i < 40 && wr_cnt == 0; i++) step();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    clear_stats();
    push(v.b0);
    if (v.n > 1) push(v.b1);
    if (v.n > 2) push(v.b2);
    wait_wr();
    if (v.b0 == 8'h57 && v.n == 3 && v.b1 < 8'(NR)) exp_regs[v.b1[AB-1:0]] = v.b2;
    chk({tag, " wr_count"}, 64'(wr_cnt), 64'd1);
    chk({tag, " tx_data"}, 64'(wr_byte), 64'(v.resp));
    chk({tag, " rd_count"}, 64'(rd_cnt), 64'(v.n));
    chk({tag, " latency"}, 64'(wr_cyc - last_rd_cyc), 64'd1);
    chk({tag, " err_count"}, 64'(err_cnt), 64'(v.errs));
    chk({tag, " err_with_rd"}, 64'(err_with_rd), 64'd0);
    chk({tag, " reg_bank"}, s_bank, exp_bank());
  endtask

  initial begin
    int c0;
    logic b16, b17;

    vecs[0]  = '{8'h57, 8'h03, 8'hA5, 3, 8'h4B, 0};
    vecs[1]  = '{8'h52, 8'h03, 8'h00, 2, 8'hA5, 0};
    vecs[2]  = '{8'h52, 8'h05, 8'h00, 2, 8'h00, 0};
    vecs[3]  = '{8'h41, 8'h00, 8'h00, 1, 8'h3F, 1};
    vecs[4]  = '{8'h57, 8'h09, 8'h11, 3, 8'h45, 1};
    vecs[5]  = '{8'h52, 8'h0A, 8'h00, 2, 8'h45, 1};
    vecs[6]  = '{8'h57, 8'h00, 8'h57, 3, 8'h4B, 0};
    vecs[7]  = '{8'h52, 8'h00, 8'h00, 2, 8'h57, 0};
    vecs[8]  = '{8'h57, 8'h07, 8'hFF, 3, 8'h4B, 0};
    vecs[9]  = '{8'h52, 8'h07, 8'h00, 2, 8'hFF, 0};
    vecs[10] = '{8'h00, 8'h00, 8'h00, 1, 8'h3F, 1};
    vecs[11] = '{8'h52, 8'h08, 8'h00, 2, 8'h45, 1};
    for (int i = 0; i < int'(NR); i++) exp_regs[i] = 8'h00;

    // Reset with a byte waiting: nothing may be popped or flagged.
    rst = 1'b0;
    fifo_tx_full = 1'b0;
    push(8'h41);
    clear_stats();
    step();
    step();
    chk("reset rd", 64'(s_rd), 64'd0);
    chk("reset wr", 64'(s_wr), 64'd0);
    chk("reset busy", 64'(s_busy), 64'd0);
    chk("reset cmd_err", 64'(s_err), 64'd0);
    chk("reset reg_bank", s_bank, 64'd0);
    q.delete();
    drive_rx();
    rst = 1'b1;
    step();

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // TX FIFO full during a read, with the next command already queued.
    fifo_tx_full = 1'b1;
    clear_stats();
    push(8'h52); push(8'h03); push(8'h52); push(8'h07);
    for (int i = 0; i < 10; i++) step();
    chk("full rd_count", 64'(rd_cnt), 64'd2);
    chk("full wr_count", 64'(wr_cnt), 64'd0);
    chk("full busy", 64'(s_busy), 64'd1);
    fifo_tx_full = 1'b0;
    clear_stats();
    step();
    chk("release wr", 64'(s_wr), 64'd1);
    chk("release tx_data", 64'(wr_byte), 64'(exp_regs[3]));
    chk("release rd", 64'(s_rd), 64'd0);
    step();
    chk("next opcode pop", 64'(s_rd), 64'd1);
    clear_stats();
    wait_wr();
    chk("queued read tx_data", 64'(wr_byte), 64'(exp_regs[7]));
    chk("queued read latency", 64'(wr_cyc - last_rd_cyc), 64'd1);

    // Stall after 'W': timeout fires 16 cycles after the opcode pop.
    clear_stats();
    push(8'h57);
    for (int i = 0; i < 10 && rd_cnt == 0; i++) step();
    c0 = last_rd_cyc;
    b16 = 1'b0; b17 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 16) b16 = s_busy;
      if (i == 17) b17 = s_busy;
    end
    chk("timeout err_count", 64'(err_cnt), 64'd1);
    chk("timeout err_delay", 64'(err_cyc - c0), 64'd16);
    chk("timeout busy at expiry", 64'(b16), 64'd1);
    chk("timeout idle after", 64'(b17), 64'd0);
    chk("timeout wr_count", 64'(wr_cnt), 64'd0);
    chk("timeout reg_bank", s_bank, exp_bank());
    run_vec('{8'h52, 8'h00, 8'h00, 2, exp_regs[0], 0}, 100);

    // A byte arriving in the expiry cycle wins over the timeout.
    clear_stats();
    push(8'h57);
    for (int i = 0; i < 10 && rd_cnt == 0; i++) step();
    c0 = last_rd_cyc;
    for (int i = 0; i < 15; i++) step();
    push(8'h02); push(8'h33);
    wait_wr();
    exp_regs[2] = 8'h33;
    chk("late byte err_count", 64'(err_cnt), 64'd0);
    chk("late byte tx_data", 64'(wr_byte), 64'h4B);
    chk("late byte rd_count", 64'(rd_cnt), 64'd3);
    chk("late byte last_rd", 64'(last_rd_cyc - c0), 64'd17);
    chk("late byte reg_bank", s_bank, exp_bank());

    // Reset between 'W' and its address discards the packet.
    clear_stats();
    push(8'h57);
    for (int i = 0; i < 10 && rd_cnt == 0; i++) step();
    rst = 1'b0;
    step();
    chk("midreset busy", 64'(s_busy), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < int'(NR); i++) exp_regs[i] = 8'h00;
    for (int i = 0; i < 5; i++) step();
    chk("midreset wr_count", 64'(wr_cnt), 64'd0);
    chk("midreset busy after", 64'(s_busy), 64'd0);
    chk("midreset reg_bank", s_bank, 64'd0);
    run_vec('{8'h52, 8'h00, 8'h00, 2, 8'h00, 0}, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
